nts_rx_dispatcher: RTL and testbench

//  Receive-side dispatcher between the 64-bit MAC RX stream and the NTS engine.

---
 rtl/nts_rx_dispatcher_pkg.sv | 19 +
 rtl/nts_rx_dispatcher_if.sv | 31 +++
 rtl/nts_rx_dispatcher_ram.sv | 40 ++++
 rtl/nts_rx_dispatcher.sv | 196 +++++++++++++++++++
 tb/tb_nts_rx_dispatcher.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nts_rx_dispatcher_pkg.sv
// Shared constants for the NTS receive dispatcher: bus widths, FSM encodings, counter helper.
package nts_rx_dispatcher_pkg;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned MASK_W  = 8;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned STATE_W = 4;

  localparam logic [STATE_W-1:0] ST_IDLE  = 4'h0;
  localparam logic [STATE_W-1:0] ST_WRITE = 4'h1;
  localparam logic [STATE_W-1:0] ST_DROP  = 4'h2;
  localparam logic [STATE_W-1:0] ST_HOLD  = 4'h3;

  // Increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/nts_rx_dispatcher_if.sv
// MAC RX stream plus engine dispatch port of the receive dispatcher.
interface nts_rx_dispatcher_if;
  import nts_rx_dispatcher_pkg::*;

  logic [MASK_W-1:0] i_mac_rx_data_valid;
  logic [DATA_W-1:0] i_mac_rx_data;
  logic              i_mac_rx_good_frame;
  logic              i_mac_rx_bad_frame;
  logic              o_dispatch_packet_available;
  logic              i_dispatch_packet_read_discard;
  logic [MASK_W-1:0] o_dispatch_data_valid;
  logic              o_dispatch_fifo_empty;
  logic              i_dispatch_fifo_rd_en;
  logic [DATA_W-1:0] o_dispatch_fifo_rd_data;

  // MAC and engine side: drives the stream and the read controls.
  modport master (
    output i_mac_rx_data_valid, i_mac_rx_data, i_mac_rx_good_frame, i_mac_rx_bad_frame,
    output i_dispatch_packet_read_discard, i_dispatch_fifo_rd_en,
    input  o_dispatch_packet_available, o_dispatch_data_valid,
    input  o_dispatch_fifo_empty, o_dispatch_fifo_rd_data
  );

  // Dispatcher side.
  modport slave (
    input  i_mac_rx_data_valid, i_mac_rx_data, i_mac_rx_good_frame, i_mac_rx_bad_frame,
    input  i_dispatch_packet_read_discard, i_dispatch_fifo_rd_en,
    output o_dispatch_packet_available, o_dispatch_data_valid,
    output o_dispatch_fifo_empty, o_dispatch_fifo_rd_data
  );
endinterface

// File: rtl/nts_rx_dispatcher_ram.sv
// Single-packet buffer: simple dual-port RAM, one write port, registered read.
module nts_dispatcher_ram
  import nts_rx_dispatcher_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_areset_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_W-1:0]     o_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port; the array itself is never reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  // Read register holds its value when no read is issued.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      rdata_q <= '0;
    end else if (i_re) begin
      rdata_q <= mem_q[i_raddr];
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/nts_rx_dispatcher.sv
// Receive dispatcher: captures one MAC frame, filters bad/empty/oversize frames,
// and hands the held frame to the NTS engine word by word.
module nts_rx_dispatcher
  import nts_rx_dispatcher_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic               i_clk,
  input  logic               i_areset_n,
  nts_rx_dispatcher_if.slave bus,
  output logic [CNT_W-1:0]   o_counter_frames_accepted,
  output logic [CNT_W-1:0]   o_counter_frames_dropped
);

  localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;

  logic [STATE_W-1:0]    state_q,    state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q,   wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q,   rd_ptr_d;
  logic [ADDR_WIDTH-1:0] count_q,    count_d;
  logic [MASK_W-1:0]     last_dv_q,  last_dv_d;
  logic [MASK_W-1:0]     dv_out_q,   dv_out_d;
  logic                  avail_q,    avail_d;
  logic                  empty_q,    empty_d;
  logic [CNT_W-1:0]      acc_q,      acc_d;
  logic [CNT_W-1:0]      drop_q,     drop_d;

  logic                  we_c;
  logic [ADDR_WIDTH-1:0] waddr_c;
  logic                  re_c;
  logic                  word_c;
  logic                  end_c;
  logic                  bad_c;
  logic                  good_c;

  // Decode MAC strobes; bad wins when both end pulses coincide.
  always_comb begin
    word_c = |bus.i_mac_rx_data_valid;
    bad_c  = bus.i_mac_rx_bad_frame;
    good_c = bus.i_mac_rx_good_frame & ~bus.i_mac_rx_bad_frame;
    end_c  = bus.i_mac_rx_good_frame | bus.i_mac_rx_bad_frame;
  end

  // Next-state logic for frame capture, hold and read-out.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    last_dv_d = last_dv_q;
    dv_out_d  = dv_out_q;
    avail_d   = avail_q;
    empty_d   = empty_q;
    acc_d     = acc_q;
    drop_d    = drop_q;
    we_c      = 1'b0;
    waddr_c   = wr_ptr_q;
    re_c      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bad_c) begin
          drop_d = sat_inc(drop_q);
        end else if (word_c) begin
          we_c      = 1'b1;
          waddr_c   = '0;
          last_dv_d = bus.i_mac_rx_data_valid;
          if (good_c) begin
            // Single-word frame ending in its own cycle.
            count_d  = ADDR_WIDTH'(1);
            acc_d    = acc_q + CNT_W'(1);
            avail_d  = 1'b1;
            empty_d  = 1'b0;
            dv_out_d = bus.i_mac_rx_data_valid;
            state_d  = ST_HOLD;
          end else begin
            wr_ptr_d = ADDR_WIDTH'(1);
            state_d  = ST_WRITE;
          end
        end else if (good_c) begin
          // Frame end with no data: empty frame.
          drop_d = sat_inc(drop_q);
        end
      end

      ST_WRITE: begin
        if (word_c) begin
          last_dv_d = bus.i_mac_rx_data_valid;
        end
        if (bad_c) begin
          drop_d   = sat_inc(drop_q);
          wr_ptr_d = '0;
          state_d  = ST_IDLE;
        end else if (word_c && (wr_ptr_q == PTR_MAX)) begin
          // Overflow: the frame cannot fit in the buffer.
          wr_ptr_d = '0;
          if (good_c) begin
            drop_d  = sat_inc(drop_q);
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DROP;
          end
        end else begin
          if (word_c) begin
            we_c     = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
          end
          if (good_c) begin
            count_d  = wr_ptr_q + ADDR_WIDTH'(word_c);
            acc_d    = acc_q + CNT_W'(1);
            avail_d  = 1'b1;
            empty_d  = 1'b0;
            dv_out_d = word_c ? bus.i_mac_rx_data_valid : last_dv_q;
            state_d  = ST_HOLD;
          end
        end
      end

      ST_DROP: begin
        if (end_c) begin
          drop_d  = sat_inc(drop_q);
          state_d = ST_IDLE;
        end
      end

      ST_HOLD: begin
        if (end_c) begin
          drop_d = sat_inc(drop_q);
        end
        if (bus.i_dispatch_packet_read_discard) begin
          avail_d  = 1'b0;
          empty_d  = 1'b1;
          dv_out_d = '0;
          rd_ptr_d = '0;
          wr_ptr_d = '0;
          state_d  = ST_IDLE;
        end else if (bus.i_dispatch_fifo_rd_en && !empty_q) begin
          re_c     = 1'b1;
          rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
          empty_d  = ((rd_ptr_q + ADDR_WIDTH'(1)) == count_q);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, pointer, counter and output registers.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      last_dv_q <= '0;
      dv_out_q  <= '0;
      avail_q   <= 1'b0;
      empty_q   <= 1'b1;
      acc_q     <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      last_dv_q <= last_dv_d;
      dv_out_q  <= dv_out_d;
      avail_q   <= avail_d;
      empty_q   <= empty_d;
      acc_q     <= acc_d;
      drop_q    <= drop_d;
    end
  end

  nts_dispatcher_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .i_clk      (i_clk),
    .i_areset_n (i_areset_n),
    .i_we       (we_c),
    .i_waddr    (waddr_c),
    .i_wdata    (bus.i_mac_rx_data),
    .i_re       (re_c),
    .i_raddr    (rd_ptr_q),
    .o_rdata    (bus.o_dispatch_fifo_rd_data)
  );

  assign bus.o_dispatch_packet_available = avail_q;
  assign bus.o_dispatch_fifo_empty       = empty_q;
  assign bus.o_dispatch_data_valid       = dv_out_q;
  assign o_counter_frames_accepted       = acc_q;
  assign o_counter_frames_dropped        = drop_q;

endmodule

// File: tb/tb_nts_rx_dispatcher.sv
// Bench for nts_rx_dispatcher: directed scenarios plus random frames against a frame-level model.
module tb_nts_rx_dispatcher;

  localparam int unsigned AW   = 4;
  localparam int          MAXW = (1 << AW) - 1;

  logic        i_clk = 1'b0;
  logic        i_areset_n;
  logic [31:0] acc_o;
  logic [31:0] drop_o;

  nts_rx_dispatcher_if bus ();

  nts_rx_dispatcher #(
    .ADDR_WIDTH (AW)
  ) dut (
    .i_clk                     (i_clk),
    .i_areset_n                (i_areset_n),
    .bus                       (bus),
    .o_counter_frames_accepted (acc_o),
    .o_counter_frames_dropped  (drop_o)
  );

  always #5 i_clk = ~i_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Frame-level reference model.
  bit          m_held;
  logic [63:0] m_q[$];
  logic [63:0] m_cur[$];
  int          m_rdidx;
  logic [7:0]  m_dv;
  logic [31:0] m_acc;
  logic [31:0] m_drop;
  logic [63:0] m_rd_data;

  task automatic model_reset();
    m_held = 0; m_q.delete(); m_cur.delete(); m_rdidx = 0;
    m_dv = '0; m_acc = '0; m_drop = '0; m_rd_data = '0;
  endtask

  task automatic model_drop();
    if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 32'd1;
  endtask

  // kind: 0 = good, 1 = bad, 2 = good and bad together.
  task automatic model_end(input int kind, input int n, input logic [7:0] lm);
    if (m_held) model_drop();
    else if (kind != 0) model_drop();
    else if (n == 0 || n > MAXW) model_drop();
    else begin
      m_held = 1; m_q = m_cur; m_rdidx = 0; m_dv = lm; m_acc = m_acc + 32'd1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".avail"}, 64'(bus.o_dispatch_packet_available), 64'(m_held));
    chk({tag, ".empty"}, 64'(bus.o_dispatch_fifo_empty), 64'(!(m_held && m_rdidx < m_q.size())));
    chk({tag, ".dv"},    64'(bus.o_dispatch_data_valid), 64'(m_held ? m_dv : 8'h00));
    chk({tag, ".rdata"}, bus.o_dispatch_fifo_rd_data, m_rd_data);
    chk({tag, ".acc"},   64'(acc_o), 64'(m_acc));
    chk({tag, ".drop"},  64'(drop_o), 64'(m_drop));
  endtask

  // Move to the next falling edge, check everything, then idle all inputs.
  task automatic tick(input string tag);
    @(negedge i_clk);
    check_all(tag);
    bus.i_mac_rx_data_valid            = '0;
    bus.i_mac_rx_data                  = '0;
    bus.i_mac_rx_good_frame            = 1'b0;
    bus.i_mac_rx_bad_frame             = 1'b0;
    bus.i_dispatch_fifo_rd_en          = 1'b0;
    bus.i_dispatch_packet_read_discard = 1'b0;
  endtask

  task automatic drive_end(input int kind, input int n, input logic [7:0] lm);
    bus.i_mac_rx_good_frame = (kind != 1);
    bus.i_mac_rx_bad_frame  = (kind != 0);
    model_end(kind, n, lm);
  endtask

  task automatic send_frame(input string tag, input int n, input logic [7:0] lm,
                            input int kind, input bit co);
    logic [63:0] d;
    m_cur.delete();
    for (int i = 0; i < n; i++) begin
      tick(tag);
      d = {$urandom, $urandom};
      bus.i_mac_rx_data_valid = (i == n - 1) ? lm : 8'hFF;
      bus.i_mac_rx_data       = d;
      m_cur.push_back(d);
      if (co && i == n - 1) drive_end(kind, n, lm);
    end
    if (!(co && n > 0)) begin
      tick(tag);
      drive_end(kind, n, lm);
    end
    tick(tag);
  endtask

  task automatic rd_cycle(input string tag, input bit rd, input bit disc);
    tick(tag);
    bus.i_dispatch_fifo_rd_en          = rd;
    bus.i_dispatch_packet_read_discard = disc;
    if (disc && m_held) begin
      m_held = 0; m_q.delete(); m_rdidx = 0; m_dv = '0;
    end else if (rd && m_held && m_rdidx < m_q.size()) begin
      m_rd_data = m_q[m_rdidx];
      m_rdidx++;
    end
  endtask

  task automatic read_n(input string tag, input int k);
    for (int i = 0; i < k; i++) rd_cycle(tag, 1'b1, 1'b0);
    tick(tag);
  endtask

  task automatic async_reset(input string tag);
    #2;
    i_areset_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    tick(tag);
    tick(tag);
    i_areset_n = 1'b1;
  endtask

  int          n, kind, nr;
  bit          co;
  logic [7:0]  lm;

  initial begin
    i_areset_n = 1'b0;
    model_reset();
    bus.i_mac_rx_data_valid            = '0;
    bus.i_mac_rx_data                  = '0;
    bus.i_mac_rx_good_frame            = 1'b0;
    bus.i_mac_rx_bad_frame             = 1'b0;
    bus.i_dispatch_fifo_rd_en          = 1'b0;
    bus.i_dispatch_packet_read_discard = 1'b0;
    tick("reset");
    i_areset_n = 1'b1;
    tick("reset_rel");

    // Six-word frame, last mask F0, good_frame after the last word.
    send_frame("t1_wr", 6, 8'hF0, 0, 1'b0);
    read_n("t1_rd", 6);
    rd_cycle("t1_empty_rd", 1'b1, 1'b0);
    rd_cycle("t1_disc", 1'b0, 1'b1);
    tick("t1_post");

    // Bad frame dropped, then a normal frame with good on its last word.
    send_frame("t2_bad", 4, 8'hFF, 1, 1'b0);
    send_frame("t2_good", 5, 8'h80, 0, 1'b1);
    read_n("t2_rd", 5);
    rd_cycle("t2_disc", 1'b0, 1'b1);
    tick("t2_post");

    // Overflow at 16 words; 15-word frame is the largest accepted.
    send_frame("t3_ovf", 16, 8'hFF, 0, 1'b0);
    send_frame("t3_ovf_co", 16, 8'hFF, 0, 1'b1);
    send_frame("t3_max", MAXW, 8'hFC, 0, 1'b0);
    read_n("t3_rd", MAXW);
    rd_cycle("t3_disc", 1'b0, 1'b1);
    tick("t3_post");

    // Empty frame and simultaneous good/bad are both drops.
    send_frame("t3_zero", 0, 8'hFF, 0, 1'b0);
    send_frame("t3_both", 3, 8'hFF, 2, 1'b1);

    // Frame arriving while a packet is held is ignored.
    send_frame("t4_hold", 4, 8'hC0, 0, 1'b0);
    send_frame("t4_ign", 3, 8'hFF, 0, 1'b0);
    read_n("t4_rd", 4);
    rd_cycle("t4_disc", 1'b0, 1'b1);
    send_frame("t4_third", 2, 8'h01, 0, 1'b0);
    read_n("t4_rd3", 2);
    rd_cycle("t4_disc3", 1'b0, 1'b1);
    tick("t4_post");

    // Discard after two reads, coinciding with rd_en; discard when idle.
    send_frame("t5_wr", 5, 8'hFF, 0, 1'b0);
    read_n("t5_rd", 2);
    rd_cycle("t5_disc_rd", 1'b1, 1'b1);
    tick("t5_post");
    rd_cycle("t5_idle_disc", 1'b1, 1'b1);
    tick("t5_idle_post");
    send_frame("t5_next", 3, 8'hE0, 0, 1'b0);
    read_n("t5_rd_next", 3);
    rd_cycle("t5_disc2", 1'b0, 1'b1);
    tick("t5_post2");

    // Async reset mid-write and mid-read.
    tick("t6_pre");
    bus.i_mac_rx_data_valid = 8'hFF;
    bus.i_mac_rx_data       = 64'h1111_2222_3333_4444;
    tick("t6_w1");
    bus.i_mac_rx_data_valid = 8'hFF;
    bus.i_mac_rx_data       = 64'h5555_6666_7777_8888;
    async_reset("t6_rst_wr");
    send_frame("t6_hold", 4, 8'hF8, 0, 1'b0);
    rd_cycle("t6_rd", 1'b1, 1'b0);
    rd_cycle("t6_rd", 1'b1, 1'b0);
    async_reset("t6_rst_rd");
    send_frame("t6_again", 6, 8'hF0, 0, 1'b0);
    read_n("t6_rd_again", 6);
    rd_cycle("t6_disc", 1'b0, 1'b1);
    tick("t6_post");

    // Random frames, partial reads and occasional frames during hold.
    for (int f = 0; f < 24; f++) begin
      n    = int'($urandom_range(0, 18));
      kind = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
      co   = 1'($urandom_range(0, 1));
      lm   = 8'($urandom_range(1, 255));
      send_frame("rnd_wr", n, lm, kind, co);
      if (m_held && $urandom_range(0, 3) != 0) begin
        nr = int'($urandom_range(0, m_q.size() + 1));
        for (int r = 0; r < nr; r++) rd_cycle("rnd_rd", 1'b1, 1'b0);
        rd_cycle("rnd_disc", 1'($urandom_range(0, 1)), 1'b1);
      end
    end
    rd_cycle("rnd_final_disc", 1'b0, 1'b1);
    tick("rnd_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
